pre: RTL

- TX-side counterpart of the Aurora RX post-processor. Accepts frames from the FPGA fabric over AXI-Stream and forwards them to the Aurora TX core toward RTDS.
- When enabled, appends a trailing 32-bit sequence number word to every frame and moves tlast onto that word.
- Counts transmitted frames for a status register and reports the beat count of each frame.
- Single registered output stage: s_axis data reaches m_axis with 1-cycle latency.

---
 rtl/pre.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pre.sv
`timescale 1ns/1ps
// TX-side pre-processor for the Aurora link: forwards fabric AXI-Stream frames,
// optionally appends a 32-bit sequence word, and keeps frame/beat statistics.
module pre #(
   parameter logic [31:0] SEQ_INIT = 32'h0000_0000
) (
   input  logic        m_axis_aclk,
   input  logic        m_axis_areset,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   input  logic        ctrl_append_seq_en,
   input  logic        ctrl_rst_cntr_out,
   input  logic        ctrl_rst_seq,
   output logic [63:0] slv_cntr_out,
   output logic [15:0] stat_cnt_pkts,
   output logic        stat_cnt_pkts_rdy
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 64;
   localparam int unsigned BEAT_W = 16;

   typedef enum logic {S_DATA, S_SEQ} tx_state_t;
   typedef enum logic {S_CNT_COUNT, S_CNT_RST} cnt_state_t;

   tx_state_t          tx_state_q, tx_state_d;
   cnt_state_t         cnt_state_q, cnt_state_d;
   logic               run_q;
   logic               first_q;
   logic               append_lat_q;
   logic [DATA_W-1:0]  seq_q;
   logic [BEAT_W-1:0]  beat_q;

   logic               load_ok_c;
   logic               m_hs_c;
   logic               append_cur_c;
   logic               load_data_c;
   logic               load_seq_c;
   logic               clr_cnt_c;
   logic               inc_cnt_c;
   logic [BEAT_W-1:0]  beat_inc_c;

   assign load_ok_c    = ~m_axis_tvalid | m_axis_tready;
   assign m_hs_c       = m_axis_tvalid & m_axis_tready;
   // The first beat of a frame decides append; later beats use the latched decision.
   assign append_cur_c = first_q ? ctrl_append_seq_en : append_lat_q;
   assign beat_inc_c   = (&beat_q) ? beat_q : beat_q + BEAT_W'(1);

   // State registers
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         tx_state_q  <= S_DATA;
         cnt_state_q <= S_CNT_COUNT;
      end else begin
         tx_state_q  <= tx_state_d;
         cnt_state_q <= cnt_state_d;
      end
   end

   // Next-state and control decode for the TX and frame-counter FSMs
   always_comb begin
      tx_state_d    = tx_state_q;
      cnt_state_d   = cnt_state_q;
      s_axis_tready = 1'b0;
      load_data_c   = 1'b0;
      load_seq_c    = 1'b0;
      clr_cnt_c     = 1'b0;
      inc_cnt_c     = 1'b0;

      case (tx_state_q)
         S_DATA: begin
            s_axis_tready = run_q & load_ok_c;
            if (s_axis_tvalid & s_axis_tready) begin
               load_data_c = 1'b1;
               if (s_axis_tlast & append_cur_c) tx_state_d = S_SEQ;
            end
         end
         S_SEQ: begin
            if (load_ok_c) begin
               load_seq_c = 1'b1;
               tx_state_d = S_DATA;
            end
         end
         default: tx_state_d = S_DATA;
      endcase

      case (cnt_state_q)
         S_CNT_COUNT: begin
            if (ctrl_rst_cntr_out) begin
               clr_cnt_c   = 1'b1;
               cnt_state_d = S_CNT_RST;
            end else if (m_hs_c & m_axis_tlast) begin
               inc_cnt_c = 1'b1;
            end
         end
         S_CNT_RST: begin
            clr_cnt_c = 1'b1;
            if (!ctrl_rst_cntr_out) cnt_state_d = S_CNT_COUNT;
         end
         default: cnt_state_d = S_CNT_COUNT;
      endcase
   end

   // Output register and frame-position tracking
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         run_q         <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         first_q       <= 1'b1;
         append_lat_q  <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (load_data_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= s_axis_tlast & ~append_cur_c;
         end else if (load_seq_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= seq_q;
            m_axis_tlast  <= 1'b1;
         end else if (m_hs_c) begin
            m_axis_tvalid <= 1'b0;
         end
         if (load_data_c) begin
            first_q <= s_axis_tlast;
            if (first_q) append_lat_q <= ctrl_append_seq_en;
         end
      end
   end

   // Sequence counter; reload wins over increment
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset)     seq_q <= SEQ_INIT;
      else if (ctrl_rst_seq) seq_q <= SEQ_INIT;
      else if (load_seq_c)   seq_q <= seq_q + DATA_W'(1);
   end

   // Per-frame beat count, reported on the tlast handshake
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset) begin
         beat_q            <= '0;
         stat_cnt_pkts     <= '0;
         stat_cnt_pkts_rdy <= 1'b0;
      end else begin
         stat_cnt_pkts_rdy <= 1'b0;
         if (m_hs_c) begin
            if (m_axis_tlast) begin
               stat_cnt_pkts     <= beat_inc_c;
               stat_cnt_pkts_rdy <= 1'b1;
               beat_q            <= '0;
            end else begin
               beat_q <= beat_inc_c;
            end
         end
      end
   end

   // Transmitted-frame counter
   always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
      if (m_axis_areset)  slv_cntr_out <= '0;
      else if (clr_cnt_c) slv_cntr_out <= '0;
      else if (inc_cnt_c) slv_cntr_out <= slv_cntr_out + CNT_W'(1);
   end

endmodule
